// File: rtl/alu_exec_if.sv
// Operand/result bundle of the execute-stage ALU.
// The master drives operands and decode fields; the slave returns the registered results.
interface alu_exec_if;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] pc_i;
    logic [31:0] imm_i;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic [63:0] mul_res;
    logic        zero_flag;
    logic        branch;
    logic [31:0] target_o;

    modport master (
        output alu_op, funct3, funct7, data0, data1, pc_i, imm_i,
        input  alu_ctrl, result, mul_res, zero_flag, branch, target_o
    );

    modport slave (
        input  alu_op, funct3, funct7, data0, data1, pc_i, imm_i,
        output alu_ctrl, result, mul_res, zero_flag, branch, target_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with decode, multiply, branch compare and PC+imm adder; outputs registered.
// Define ALU_MUL_EN to build the multiplier; otherwise multiply encodings decode to NOP.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    alu_exec_if.slave   bus
);

    typedef enum logic [3:0] {
        CTRL_AND    = 4'b0000,
        CTRL_OR     = 4'b0001,
        CTRL_ADD    = 4'b0010,
        CTRL_XOR    = 4'b0011,
        CTRL_SLL    = 4'b0100,
        CTRL_SRL    = 4'b0101,
        CTRL_SUB    = 4'b0110,
        CTRL_SRA    = 4'b0111,
        CTRL_SLT    = 4'b1000,
        CTRL_SLTU   = 4'b1001,
        CTRL_MUL    = 4'b1010,
        CTRL_MULH   = 4'b1011,
        CTRL_MULHSU = 4'b1100,
        CTRL_MULHU  = 4'b1101,
        CTRL_BRANCH = 4'b1110,
        CTRL_NOP    = 4'b1111
    } alu_ctrl_e;

    alu_ctrl_e   ctrl_d;
    logic [31:0] result_d;
    logic [63:0] mul_d;
    logic        branch_d;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic        lt_signed;
    logic        lt_unsigned;

    // Base integer decode shared by R-type (funct7 0) and I-type ALU ops.
    function automatic alu_ctrl_e base_decode(input logic [2:0] f3);
        case (f3)
            3'b000:  base_decode = CTRL_ADD;
            3'b001:  base_decode = CTRL_SLL;
            3'b010:  base_decode = CTRL_SLT;
            3'b011:  base_decode = CTRL_SLTU;
            3'b100:  base_decode = CTRL_XOR;
            3'b101:  base_decode = CTRL_SRL;
            3'b110:  base_decode = CTRL_OR;
            default: base_decode = CTRL_AND;
        endcase
    endfunction

    always_comb begin
        ctrl_d = CTRL_NOP;
        case (bus.alu_op)
            2'b00: ctrl_d = CTRL_ADD;
            2'b01: ctrl_d = CTRL_BRANCH;
            2'b10: begin
                case (bus.funct7)
                    7'b0000000: ctrl_d = base_decode(bus.funct3);
                    7'b0100000: begin
                        if (bus.funct3 == 3'b000)      ctrl_d = CTRL_SUB;
                        else if (bus.funct3 == 3'b101) ctrl_d = CTRL_SRA;
                        else                           ctrl_d = CTRL_NOP;
                    end
`ifdef ALU_MUL_EN
                    7'b0000001: begin
                        case (bus.funct3)
                            3'b000:  ctrl_d = CTRL_MUL;
                            3'b001:  ctrl_d = CTRL_MULH;
                            3'b010:  ctrl_d = CTRL_MULHSU;
                            3'b011:  ctrl_d = CTRL_MULHU;
                            default: ctrl_d = CTRL_NOP;
                        endcase
                    end
`endif
                    default: ctrl_d = CTRL_NOP;
                endcase
            end
            default: begin
                // I-type: no SUBI, and funct7[5] picks the arithmetic right shift.
                if (bus.funct3 == 3'b101 && bus.funct7[5]) ctrl_d = CTRL_SRA;
                else                                       ctrl_d = base_decode(bus.funct3);
            end
        endcase
    end

    assign sum         = bus.data0 + bus.data1;
    assign diff        = bus.data0 - bus.data1;
    assign shamt       = bus.data1[4:0];
    assign lt_signed   = $signed(bus.data0) < $signed(bus.data1);
    assign lt_unsigned = bus.data0 < bus.data1;

`ifdef ALU_MUL_EN
    logic        mul_sign_a;
    logic        mul_sign_b;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    // Sign-extending to 64 bits makes one unsigned multiply serve all four signedness modes.
    assign mul_sign_a = (ctrl_d == CTRL_MUL) || (ctrl_d == CTRL_MULH) || (ctrl_d == CTRL_MULHSU);
    assign mul_sign_b = (ctrl_d == CTRL_MUL) || (ctrl_d == CTRL_MULH);
    assign mul_a      = {{32{mul_sign_a & bus.data0[31]}}, bus.data0};
    assign mul_b      = {{32{mul_sign_b & bus.data1[31]}}, bus.data1};
    assign product    = mul_a * mul_b;
`endif

    always_comb begin
        result_d = '0;
        mul_d    = '0;
        branch_d = 1'b0;
        case (ctrl_d)
            CTRL_AND:  result_d = bus.data0 & bus.data1;
            CTRL_OR:   result_d = bus.data0 | bus.data1;
            CTRL_ADD:  result_d = sum;
            CTRL_XOR:  result_d = bus.data0 ^ bus.data1;
            CTRL_SLL:  result_d = bus.data0 << shamt;
            CTRL_SRL:  result_d = bus.data0 >> shamt;
            CTRL_SUB:  result_d = diff;
            CTRL_SRA:  result_d = $unsigned($signed(bus.data0) >>> shamt);
            CTRL_SLT:  result_d = {31'b0, lt_signed};
            CTRL_SLTU: result_d = {31'b0, lt_unsigned};
`ifdef ALU_MUL_EN
            CTRL_MUL: begin
                result_d = product[31:0];
                mul_d    = product;
            end
            CTRL_MULH, CTRL_MULHSU, CTRL_MULHU: begin
                result_d = product[63:32];
                mul_d    = product;
            end
`endif
            CTRL_BRANCH: begin
                result_d = diff;
                case (bus.funct3)
                    3'b000:  branch_d = (bus.data0 == bus.data1);
                    3'b001:  branch_d = (bus.data0 != bus.data1);
                    3'b100:  branch_d = lt_signed;
                    3'b101:  branch_d = !lt_signed;
                    3'b110:  branch_d = lt_unsigned;
                    3'b111:  branch_d = !lt_unsigned;
                    default: branch_d = 1'b0;
                endcase
            end
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.alu_ctrl  <= 4'b0000;
            bus.result    <= '0;
            bus.mul_res   <= '0;
            bus.zero_flag <= 1'b0;
            bus.branch    <= 1'b0;
            bus.target_o  <= '0;
        end else begin
            bus.alu_ctrl  <= ctrl_d;
            bus.result    <= result_d;
            bus.mul_res   <= mul_d;
            bus.zero_flag <= (result_d == 32'd0);
            bus.branch    <= branch_d;
            bus.target_o  <= bus.pc_i + bus.imm_i;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: mnemonic-level reference model with a per-cycle
// scoreboard plus literal checks on hand-computed vectors; honours ALU_MUL_EN.
module tb_alu_exec_unit;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_exec_if bus ();

    alu_exec_unit dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Packed expectation: {ctrl[4], result[32], mul[64], zero[1], branch[1], target[32]}
    logic [133:0] exp_q[$];

    function automatic string op_name(input logic [1:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
        string base[8];
        string muls[4];
        base = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
        muls = '{"mul", "mulh", "mulhsu", "mulhu"};
        if (op == 2'd0) return "add";
        if (op == 2'd1) return "branch";
        if (op == 2'd3) begin
            if (f3 == 3'd0) return "add";
            if (f3 == 3'd5 && f7[5]) return "sra";
            return base[f3];
        end
        if (f7 == 7'h00) return base[f3];
        if (f7 == 7'h20) return (f3 == 3'd0) ? "sub" : (f3 == 3'd5) ? "sra" : "nop";
        if (f7 == 7'h01 && MUL_EN && f3 < 3'd4) return muls[f3[1:0]];
        return "nop";
    endfunction

    function automatic logic [133:0] model(input logic [1:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pc,
                                           input logic [31:0] imm);
        string       name;
        logic [3:0]  code;
        logic [31:0] res;
        logic [63:0] mul;
        logic        br;
        logic [63:0] sa, ua, sb, ub;
        sa = {{32{a[31]}}, a};
        ua = {32'b0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        name = op_name(op, f3, f7);
        mul  = '0;
        br   = 1'b0;
        res  = '0;
        code = 4'b1111;
        case (name)
            "and":    begin code = 4'b0000; res = a & b; end
            "or":     begin code = 4'b0001; res = a | b; end
            "add":    begin code = 4'b0010; res = a + b; end
            "xor":    begin code = 4'b0011; res = a ^ b; end
            "sll":    begin code = 4'b0100; res = a << b[4:0]; end
            "srl":    begin code = 4'b0101; res = a >> b[4:0]; end
            "sub":    begin code = 4'b0110; res = a - b; end
            "sra":    begin code = 4'b0111; res = $unsigned($signed(a) >>> b[4:0]); end
            "slt":    begin code = 4'b1000; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            "sltu":   begin code = 4'b1001; res = (a < b) ? 32'd1 : 32'd0; end
            "mul":    begin code = 4'b1010; mul = sa * sb; res = mul[31:0]; end
            "mulh":   begin code = 4'b1011; mul = sa * sb; res = mul[63:32]; end
            "mulhsu": begin code = 4'b1100; mul = sa * ub; res = mul[63:32]; end
            "mulhu":  begin code = 4'b1101; mul = ua * ub; res = mul[63:32]; end
            "branch": begin
                code = 4'b1110;
                res  = a - b;
                case (f3)
                    3'd0: br = (a == b);
                    3'd1: br = (a != b);
                    3'd4: br = $signed(a) < $signed(b);
                    3'd5: br = $signed(a) >= $signed(b);
                    3'd6: br = a < b;
                    3'd7: br = a >= b;
                    default: br = 1'b0;
                endcase
            end
            default: begin code = 4'b1111; res = '0; end
        endcase
        return {code, res, mul, (res == 32'd0), br, pc + imm};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [133:0] e);
        check({tag, ".alu_ctrl"},  64'(bus.alu_ctrl),  64'(e[133:130]));
        check({tag, ".result"},    64'(bus.result),    64'(e[129:98]));
        check({tag, ".mul_res"},   bus.mul_res,        e[97:34]);
        check({tag, ".zero_flag"}, 64'(bus.zero_flag), 64'(e[33]));
        check({tag, ".branch"},    64'(bus.branch),    64'(e[32]));
        check({tag, ".target_o"},  64'(bus.target_o),  64'(e[31:0]));
    endtask

    always @(posedge clk)
        if (rst_n)
            exp_q.push_back(model(bus.alu_op, bus.funct3, bus.funct7, bus.data0,
                                  bus.data1, bus.pc_i, bus.imm_i));

    always @(negedge rst_n) exp_q.delete();

    // Outputs read 0 until the first capture after reset releases.
    always @(negedge clk) begin
        logic [133:0] e;
        e = '0;
        if (rst_n && exp_q.size() > 0) e = exp_q.pop_front();
        check_all("cyc", e);
    end

    // ---------------- driver ----------------
    task automatic apply(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        bus.alu_op = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.data0  = a;
        bus.data1  = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.alu_op = 2'b00;
        bus.funct3 = 3'b000;
        bus.funct7 = 7'b0;
        bus.data0  = '0;
        bus.data1  = '0;
        bus.pc_i   = 32'h0000_1000;
        bus.imm_i  = 32'h0000_0010;
        repeat (3) @(posedge clk);
        #1;
        check("reset.result",    64'(bus.result),    64'd0);
        check("reset.alu_ctrl",  64'(bus.alu_ctrl),  64'd0);
        check("reset.zero_flag", 64'(bus.zero_flag), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type basic ops with literal pins
        apply(2'b10, 3'b000, 7'h00, 32'd5, 32'd7);
        check("add.result", 64'(bus.result), 64'd12);
        check("add.ctrl",   64'(bus.alu_ctrl), 64'b0010);
        check("add.zero",   64'(bus.zero_flag), 64'd0);
        apply(2'b10, 3'b000, 7'h20, 32'd7, 32'd7);
        check("sub.result", 64'(bus.result), 64'd0);
        check("sub.ctrl",   64'(bus.alu_ctrl), 64'b0110);
        check("sub.zero",   64'(bus.zero_flag), 64'd1);
        apply(2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'd4);
        check("sra.result", 64'(bus.result), 64'hF800_0000);
        apply(2'b10, 3'b101, 7'h00, 32'h8000_0000, 32'd4);
        check("srl.result", 64'(bus.result), 64'h0800_0000);
        apply(2'b10, 3'b001, 7'h00, 32'd1, 32'd33);
        check("sll.shamt_mask", 64'(bus.result), 64'd2);
        apply(2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1);
        check("slt.result", 64'(bus.result), 64'd1);
        apply(2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1);
        check("sltu.result", 64'(bus.result), 64'd0);
        apply(2'b10, 3'b100, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        apply(2'b10, 3'b110, 7'h00, 32'h1234_0000, 32'h0000_5678);
        apply(2'b10, 3'b111, 7'h00, 32'hFF00_FF00, 32'h0F0F_0F0F);
        apply(2'b10, 3'b010, 7'h20, 32'd3, 32'd4);
        check("nop.ctrl", 64'(bus.alu_ctrl), 64'b1111);
        apply(2'b10, 3'b000, 7'h11, 32'd3, 32'd4);
        apply(2'b00, 3'b111, 7'h7F, 32'd100, 32'd23);
        check("addr_add.result", 64'(bus.result), 64'd123);

        // I-type: funct7 ignored for add, bit 5 selects SRA
        apply(2'b11, 3'b000, 7'h20, 32'd10, 32'd3);
        check("addi.result", 64'(bus.result), 64'd13);
        apply(2'b11, 3'b101, 7'h20, 32'hF000_0000, 32'd8);
        apply(2'b11, 3'b101, 7'h00, 32'hF000_0000, 32'd8);
        apply(2'b11, 3'b001, 7'h00, 32'h0000_0003, 32'd31);

        // branches
        apply(2'b01, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1);
        check("blt.branch", 64'(bus.branch), 64'd1);
        apply(2'b01, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1);
        check("bltu.branch", 64'(bus.branch), 64'd0);
        apply(2'b01, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1);
        check("b010.branch", 64'(bus.branch), 64'd0);
        apply(2'b01, 3'b000, 7'h00, 32'd42, 32'd42);
        check("beq.branch", 64'(bus.branch), 64'd1);
        apply(2'b01, 3'b001, 7'h00, 32'd42, 32'd42);
        apply(2'b01, 3'b101, 7'h00, 32'h8000_0000, 32'd0);
        apply(2'b01, 3'b111, 7'h00, 32'h8000_0000, 32'd0);

        // multiply
        apply(2'b10, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'd2);
        if (MUL_EN) begin
            check("mulh.mul_res", bus.mul_res, 64'hFFFF_FFFF_FFFF_FFFE);
            check("mulh.result",  64'(bus.result), 64'hFFFF_FFFF);
        end else begin
            check("mulh_off.result", 64'(bus.result), 64'd0);
            check("mulh_off.ctrl",   64'(bus.alu_ctrl), 64'b1111);
        end
        apply(2'b10, 3'b000, 7'h01, 32'd6, 32'd7);
        apply(2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        apply(2'b10, 3'b010, 7'h01, 32'hFFFF_FFFF, 32'd2);
        apply(2'b10, 3'b100, 7'h01, 32'd6, 32'd7);

        // target adder wrap
        bus.pc_i  = 32'hFFFF_FFFC;
        bus.imm_i = 32'd8;
        apply(2'b01, 3'b000, 7'h00, 32'd1, 32'd2);
        check("target.wrap", 64'(bus.target_o), 64'h0000_0004);

        // asynchronous reset mid-stream
        apply(2'b10, 3'b000, 7'h00, 32'd5, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("async.result",   64'(bus.result),    64'd0);
        check("async.ctrl",     64'(bus.alu_ctrl),  64'd0);
        check("async.mul_res",  bus.mul_res,        64'd0);
        check("async.zero",     64'(bus.zero_flag), 64'd0);
        check("async.branch",   64'(bus.branch),    64'd0);
        check("async.target",   64'(bus.target_o),  64'd0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        apply(2'b10, 3'b100, 7'h00, 32'h0000_00FF, 32'h0000_000F);
        check("post_reset.result", 64'(bus.result), 64'h0000_00F0);
        check("post_reset.target", 64'(bus.target_o), 64'h0000_0004);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
